comparator_scheduler: RTL and testbench

//  Shares one pipelined magnitude comparator (sub-module cmp_core) among NREQ requesters.

---
 rtl/cmp_sched_pkg.sv | 27 ++
 rtl/comparator_scheduler_cmp_core.sv | 53 +++++
 rtl/comparator_scheduler.sv | 147 ++++++++++++++
 tb/tb_comparator_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sched_pkg.sv
// ============================================================================
// Module   : cmp_sched_pkg
// Brief    : Shared types and constants for comparator_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int STAT_W = 8;

    // Width needed to hold a requester index 0..n-1 (at least 1 bit).
    function automatic int id_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_scheduler_cmp_core.sv
// ============================================================================
// Module   : cmp_core
// Brief    : Unsigned magnitude compare, registered, CMP_LAT edges deep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_core #(
    parameter int NBITS   = 3,
    parameter int CMP_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic             gt,
    output logic             eq
);

    logic [CMP_LAT-1:0] r_gt;
    logic [CMP_LAT-1:0] r_eq;

    generate
        if (CMP_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_gt <= '0;
                    r_eq <= '0;
                end else begin
                    r_gt[0] <= (a > b);
                    r_eq[0] <= (a == b);
                end
            end
        end else begin : g_latn
            // First stage does the compare, the remaining stages only delay it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_gt <= '0;
                    r_eq <= '0;
                end else begin
                    r_gt <= {r_gt[CMP_LAT-2:0], (a > b)};
                    r_eq <= {r_eq[CMP_LAT-2:0], (a == b)};
                end
            end
        end
    endgenerate

    assign gt = r_gt[CMP_LAT-1];
    assign eq = r_eq[CMP_LAT-1];

endmodule

`default_nettype wire

// File: rtl/comparator_scheduler.sv
// ============================================================================
// Module   : comparator_scheduler
// Brief    : Round-robin sharing of one pipelined comparator among NREQ
//            requesters. Optional per-requester grant counters are built
//            when CMP_SCHED_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_scheduler
    import cmp_sched_pkg::*;
#(
    parameter int  NREQ    = 4,
    parameter int  NBITS   = 3,
    parameter int  CMP_LAT = 1,
    localparam int ID_W    = id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*NBITS-1:0] req_a,
    input  logic [NREQ*NBITS-1:0] req_b,
    output logic [NREQ-1:0]       grant,
    output logic                  res_valid,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_gt,
    output logic                  res_eq,
    output logic                  busy
`ifdef CMP_SCHED_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [NREQ*STAT_W-1:0] stat_cnt
`endif
);

    localparam int CNT_W = 3;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [CNT_W-1:0]   r_cnt;

    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_winner;
    logic [NBITS-1:0]   w_sel_a;
    logic [NBITS-1:0]   w_sel_b;
    logic               w_any;
    logic               w_core_gt;
    logic               w_core_eq;

    assign w_any = |req;

    // Scan from the farthest candidate to the nearest so the nearest set
    // request after rr_ptr is the one left standing.
    always_comb begin
        w_idx    = '0;
        w_winner = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NREQ);
            if (req[w_idx]) begin
                w_winner = w_idx;
                w_sel_a  = req_a[int'(w_idx)*NBITS +: NBITS];
                w_sel_b  = req_b[int'(w_idx)*NBITS +: NBITS];
            end
        end
    end

    // The core pipeline captures the winner's operands on the grant edge.
    cmp_core #(
        .NBITS   (NBITS),
        .CMP_LAT (CMP_LAT)
    ) u_cmp_core (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (w_sel_a),
        .b     (w_sel_b),
        .gt    (w_core_gt),
        .eq    (w_core_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_ptr  <= ID_W'(NREQ - 1);
            r_id      <= '0;
            r_cnt     <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_gt    <= 1'b0;
            res_eq    <= 1'b0;
        end else begin
            grant     <= '0;
            res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id     <= w_winner;
                        r_rr_ptr <= w_winner;
                        grant    <= NREQ'(1) << w_winner;
                        busy     <= 1'b1;
                        r_cnt    <= CNT_W'(CMP_LAT);
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        res_valid <= 1'b1;
                        res_id    <= r_id;
                        res_gt    <= w_core_gt;
                        res_eq    <= w_core_eq;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CMP_SCHED_STATS_EN
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_stat
            logic [STAT_W-1:0] r_stat;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stat <= '0;
                end else if (stat_clr) begin
                    r_stat <= '0;
                end else if (grant[i] && (r_stat != {STAT_W{1'b1}})) begin
                    r_stat <= r_stat + 1'b1;
                end
            end

            assign stat_cnt[i*STAT_W +: STAT_W] = r_stat;
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_comparator_scheduler.sv
// ============================================================================
// Module   : tb_comparator_scheduler
// Brief    : Directed self-checking bench for comparator_scheduler
//            (NREQ=4, NBITS=3, CMP_LAT=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparator_scheduler;

    localparam int NREQ    = 4;
    localparam int NBITS   = 3;
    localparam int CMP_LAT = 1;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*NBITS-1:0] req_a;
    logic [NREQ*NBITS-1:0] req_b;
    logic [NREQ-1:0]       grant;
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
    logic                  res_gt;
    logic                  res_eq;
    logic                  busy;
`ifdef CMP_SCHED_STATS_EN
    logic                  stat_clr;
    logic [NREQ*8-1:0]     stat_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    comparator_scheduler #(
        .NREQ    (NREQ),
        .NBITS   (NBITS),
        .CMP_LAT (CMP_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .grant     (grant),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_gt    (res_gt),
        .res_eq    (res_eq),
        .busy      (busy)
`ifdef CMP_SCHED_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int id, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        req_a[id*NBITS +: NBITS] = a;
        req_b[id*NBITS +: NBITS] = b;
    endtask

    // Single isolated request; called and returns on a falling edge.
    task automatic one_shot(input string tag, input int id, input logic [NBITS-1:0] a,
                            input logic [NBITS-1:0] b, input logic gt, input logic eq);
        set_op(id, a, b);
        req = NREQ'(1 << id);
        @(negedge clk);
        check({tag, ".grant"}, 32'(grant), 32'(1 << id));
        check({tag, ".busy1"}, 32'(busy), 32'd1);
        check({tag, ".novalid"}, 32'(res_valid), 32'd0);
        req = '0;
        @(negedge clk);
        check({tag, ".valid"}, 32'(res_valid), 32'd1);
        check({tag, ".id"}, 32'(res_id), 32'(id));
        check({tag, ".gt"}, 32'(res_gt), 32'(gt));
        check({tag, ".eq"}, 32'(res_eq), 32'(eq));
        check({tag, ".busy0"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, ".valid_pulse"}, 32'(res_valid), 32'd0);
        check({tag, ".hold_gt"}, 32'(res_gt), 32'(gt));
    endtask

    int          seq_id [5] = '{0, 1, 2, 3, 0};
    logic        seq_gt [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        seq_eq [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;
`ifdef CMP_SCHED_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst.grant", 32'(grant), 32'd0);
        check("rst.valid", 32'(res_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.id", 32'(res_id), 32'd0);
        check("rst.gteq", 32'({res_gt, res_eq}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic latency and unsigned compare cases
        one_shot("t1", 0, 3'b001, 3'b100, 1'b0, 1'b0);
        one_shot("t3a", 1, 3'b100, 3'b100, 1'b0, 1'b1);
        one_shot("t3b", 2, 3'b110, 3'b101, 1'b1, 1'b0);
        one_shot("t3c", 3, 3'b111, 3'b000, 1'b1, 1'b0);

        // All requesters held: rr_ptr is 3, so rotation starts at 0
        set_op(0, 3'd1, 3'd1);
        set_op(1, 3'd5, 3'd6);
        set_op(2, 3'd4, 3'd2);
        set_op(3, 3'd7, 3'd0);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check($sformatf("t2.grant%0d", n), 32'(grant), 32'(1 << seq_id[n]));
            check($sformatf("t2.novalid%0d", n), 32'(res_valid), 32'd0);
            if (n == 4) req = '0;
            @(negedge clk);
            check($sformatf("t2.valid%0d", n), 32'(res_valid), 32'd1);
            check($sformatf("t2.id%0d", n), 32'(res_id), 32'(seq_id[n]));
            check($sformatf("t2.gteq%0d", n), 32'({res_gt, res_eq}), 32'({seq_gt[n], seq_eq[n]}));
        end
        @(negedge clk);
        check("t2.idle_grant", 32'(grant), 32'd0);

        // Request raised during WAIT is served with no gap
        set_op(0, 3'd2, 3'd3);
        set_op(1, 3'd3, 3'd3);
        req = 4'b0001;
        @(negedge clk);
        check("t4.grant0", 32'(grant), 32'b0001);
        req = 4'b0010;
        @(negedge clk);
        check("t4.valid0", 32'(res_valid), 32'd1);
        check("t4.id0", 32'(res_id), 32'd0);
        check("t4.gteq0", 32'({res_gt, res_eq}), 32'b00);
        check("t4.nogrant", 32'(grant), 32'd0);
        @(negedge clk);
        check("t4.grant1", 32'(grant), 32'b0010);
        req = '0;
        @(negedge clk);
        check("t4.valid1", 32'(res_valid), 32'd1);
        check("t4.id1", 32'(res_id), 32'd1);
        check("t4.gteq1", 32'({res_gt, res_eq}), 32'b01);
        @(negedge clk);

        // Reset in WAIT discards the compare and restores rr_ptr
        set_op(0, 3'd6, 3'd1);
        req = 4'b0001;
        @(negedge clk);
        check("t5.grant", 32'(grant), 32'b0001);
        req   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("t5.novalid%0d", n), 32'(res_valid), 32'd0);
            check($sformatf("t5.busy%0d", n), 32'(busy), 32'd0);
        end
        set_op(2, 3'd5, 3'd4);
        req = 4'b0101;
        @(negedge clk);
        check("t5.rr_reset", 32'(grant), 32'b0001);
        req = '0;
        repeat (2) @(negedge clk);
        one_shot("t5r2", 2, 3'd5, 3'd4, 1'b1, 1'b0);

`ifdef CMP_SCHED_STATS_EN
        req = 4'b0001;
        repeat (600) @(negedge clk);
        check("t6.sat", 32'(stat_cnt[7:0]), 32'hFF);
        if (grant[0] !== 1'b1) @(negedge clk);
        check("t6.grant_phase", 32'(grant[0]), 32'd1);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        req = '0;
        check("t6.clr", 32'(stat_cnt[7:0]), 32'd0);
        repeat (2) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
